// File: rtl/if_stage_if.sv
// Fetch-side instruction memory bus: level request with stable address, one-cycle ack.
interface if_stage_if #(
  parameter int unsigned WORD_WIDTH = 32
);
  logic                  req;
  logic [WORD_WIDTH-1:0] addr;
  logic                  ack;
  logic [WORD_WIDTH-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory and drives the
// IF/ID register. Handles decode freeze, branch redirects and wrong-path draining.
module if_stage #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  if_stage_if.master            imem,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  valid
);

  typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] target_q, target_d;
  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  logic [WORD_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [WORD_WIDTH-1:0] out_instr_q, out_instr_d;
  logic                  out_valid_q, out_valid_d;
  logic                  req;
  logic                  ack;
  logic [WORD_WIDTH-1:0] pc_inc;

  // Request is gated by rst so nothing is issued while reset is held.
  assign req       = (state_q != StHold) && !rst;
  assign ack       = imem.ack && req;
  assign pc_inc    = pc_q + WORD_WIDTH'(4);
  assign imem.req  = req;
  assign imem.addr = pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    buf_d       = buf_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;

    if (branch_taken) begin
      // Redirect wins over freeze; the branch cycle always shows a bubble.
      out_instr_d = NOP_INSTR;
      out_valid_d = 1'b0;
      unique case (state_q)
        StFetch: begin
          if (ack) begin
            pc_d = branch_address;
          end else begin
            target_d = branch_address;
            state_d  = StDrain;
          end
        end
        StHold: begin
          pc_d    = branch_address;
          state_d = StFetch;
        end
        StDrain: begin
          if (ack) begin
            pc_d    = branch_address;
            state_d = StFetch;
          end else begin
            target_d = branch_address;
          end
        end
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack && freeze) begin
            buf_d   = imem.rdata;
            state_d = StHold;
          end else if (ack) begin
            out_pc_d    = pc_inc;
            out_instr_d = imem.rdata;
            out_valid_d = 1'b1;
            pc_d        = pc_inc;
          end else if (!freeze) begin
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!freeze) begin
            out_pc_d    = pc_inc;
            out_instr_d = buf_q;
            out_valid_d = 1'b1;
            pc_d        = pc_inc;
            state_d     = StFetch;
          end
        end
        StDrain: begin
          // The outstanding fetch is wrong-path: consume its ack, then jump.
          if (ack) begin
            pc_d    = target_q;
            state_d = StFetch;
          end
          if (!freeze) begin
            out_instr_d = NOP_INSTR;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      target_q    <= '0;
      buf_q       <= '0;
      out_pc_q    <= '0;
      out_instr_q <= NOP_INSTR;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      target_q    <= target_d;
      buf_q       <= buf_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc          = out_pc_q;
  assign instruction = out_instr_q;
  assign valid       = out_valid_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage. It produces the {pc, instruction} pair consumed by the decode stage, so it is the transmitter side of the fetch-to-decode interface.
- Owns the program counter and a request/acknowledge handshake to instruction memory. Variable memory latency is supported.
- Contains the IF/ID pipeline register.
- Obeys freeze (hazard stall) from decode and branch redirects from execute. Wrong-path fetches are drained and discarded.

Parameters:
WORD_WIDTH, 32, width of PC, address and instruction
RESET_PC, 0, PC value after reset
NOP_INSTR, 32'h0000_0000, instruction word presented as a bubble

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
freeze  input  1  decode cannot accept; hold the IF/ID register
branch_taken  input  1  one-cycle redirect pulse from execute
branch_address  input  WORD_WIDTH  redirect target, valid with branch_taken
imem_req  output  1  fetch request, level
imem_addr  output  WORD_WIDTH  fetch address
imem_ack  input  1  one-cycle completion; imem_rdata valid this cycle
imem_rdata  input  WORD_WIDTH  fetched instruction
pc  output  WORD_WIDTH  registered address of fetched instruction plus 4
instruction  output  WORD_WIDTH  registered instruction to decode
valid  output  1  pc/instruction hold a real instruction (0 = bubble)

Behaviour:
- Reset (async, active-high):
  - Internal PC = RESET_PC; state = FETCH.
  - Outputs: pc = 0, instruction = NOP_INSTR, valid = 0, imem_req = 0 while rst is high.
- Handshake rules:
  - imem_req = 1 in FETCH and DRAIN, 0 in HOLD.
  - imem_addr and imem_req stay stable from request until imem_ack.
  - imem_ack with imem_req = 0 is ignored.
  - Ack in the same cycle as the request is legal.
- State FETCH (imem_addr = PC):
  - Ack, no branch, freeze = 0: IF/ID loads {PC+4, imem_rdata, valid = 1}; PC <= PC+4; stay FETCH.
  - Ack, no branch, freeze = 1: imem_rdata goes to the holding buffer; IF/ID holds; go to HOLD.
  - No ack, no branch, freeze = 0: IF/ID loads a bubble {pc unchanged, NOP_INSTR, valid = 0}.
  - No ack, no branch, freeze = 1: IF/ID holds.
  - Branch with ack in the same cycle: data discarded; PC <= branch_address; stay FETCH.
  - Branch without ack: target <= branch_address; go to DRAIN.
- State HOLD:
  - freeze = 0: IF/ID loads {PC+4, buffer, 1}; PC <= PC+4; go to FETCH.
  - Branch: buffer discarded; PC <= branch_address; go to FETCH.
- State DRAIN (imem_addr = the old PC, until ack):
  - Ack: data discarded; PC <= target; go to FETCH.
  - A further branch only overwrites target.
- Branch priority: branch_taken beats freeze in every state. The IF/ID register loads a bubble in the branch cycle, whatever freeze is.
- Throughput and latency:
  - With zero-wait memory, one instruction per cycle.
  - An instruction is visible on outputs the cycle after its ack.
  - First request is in the first cycle after rst deasserts.
  - After a branch with no pending request, the target request is issued the next cycle.
- Arithmetic: PC+4 wraps modulo 2^WORD_WIDTH; no overflow flag.
- Reset mid-transaction: the pending request is abandoned and the state machine returns to FETCH. Instruction memory must tolerate this.

Test Plan:
- Zero-wait memory returning addr/4 as data, 4 cycles, no freeze -> addresses 0, 4, 8, 12; output pc = 4, 8, 12, 16; instruction = 0, 1, 2, 3; valid = 1 each cycle after the first.
- Ack delayed 2 cycles on address 0 -> imem_addr stays 0; output shows 2 bubbles (valid = 0, NOP); then pc = 4, instruction = data(0).
- freeze high 3 cycles while ack arrives for address 8 -> imem_req drops; outputs hold previous values. Cycle after freeze falls: pc = 12, instruction = data(8); next request is at 12.
- branch_taken with branch_address = 0x100 while the address-8 request is pending, ack 2 cycles later -> imem_addr stays 8 until ack; data discarded; next request at 0x100; output bubble in the branch cycle; no instruction from address 8 ever has valid = 1.
- branch_taken and freeze together, plus branch and ack in the same cycle -> IF/ID shows a bubble; the next fetch address is branch_address.
- rst asserted while a request is pending -> outputs immediately show 0 / NOP_INSTR / 0 and imem_req = 0. After release, the first request is at RESET_PC.
